// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage hazard/forwarding/stage-control bundle between the pipeline and pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic              rs_used;
    logic              rt_used;
    logic [REG_AW-1:0] addr_rs;
    logic [REG_AW-1:0] addr_rt;
    logic              id_wen;
    logic [REG_AW-1:0] id_regw_addr;
    logic              id_long_op;
    logic              wb_wen_exe;
    logic              is_load_exe;
    logic [REG_AW-1:0] regw_addr_exe;
    logic              wb_wen_mem;
    logic              is_load_mem;
    logic [REG_AW-1:0] regw_addr_mem;
    logic              wb_wen_wb;
    logic [REG_AW-1:0] regw_addr_wb;
    logic              mem_req;
    logic              mem_ready;
    logic              long_done;
    logic [REG_AW-1:0] long_addr;
    logic              branch_taken;
    logic              exc_mem;
    logic [2:0]        fwd_a;
    logic [2:0]        fwd_b;
    logic              if_en;
    logic              if_rst;
    logic              id_en;
    logic              id_rst;
    logic              exe_en;
    logic              exe_rst;
    logic              mem_en;
    logic              mem_rst;
    logic              wb_en;
    logic              wb_rst;
    logic              long_issue;
    logic [PERF_W-1:0] stall_cnt;

    modport master (
        output id_valid, rs_used, rt_used, addr_rs, addr_rt, id_wen, id_regw_addr, id_long_op,
               wb_wen_exe, is_load_exe, regw_addr_exe, wb_wen_mem, is_load_mem, regw_addr_mem,
               wb_wen_wb, regw_addr_wb, mem_req, mem_ready, long_done, long_addr, branch_taken, exc_mem,
        input  fwd_a, fwd_b, if_en, if_rst, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst,
               wb_en, wb_rst, long_issue, stall_cnt
    );

    modport slave (
        input  id_valid, rs_used, rt_used, addr_rs, addr_rt, id_wen, id_regw_addr, id_long_op,
               wb_wen_exe, is_load_exe, regw_addr_exe, wb_wen_mem, is_load_mem, regw_addr_mem,
               wb_wen_wb, regw_addr_wb, mem_req, mem_ready, long_done, long_addr, branch_taken, exc_mem,
        output fwd_a, fwd_b, if_en, if_rst, id_en, id_rst, exe_en, exe_rst, mem_en, mem_rst,
               wb_en, wb_rst, long_issue, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboarded hazard, forwarding and stage control for the 5-stage pipeline; DEBUG_STEP_EN adds a single-step hold.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int LONG_DEPTH = 2,
    parameter int PERF_W     = 32
) (
    input logic clk,
    input logic rst,
    pipe_hazard_ctrl_if.slave hz
`ifdef DEBUG_STEP_EN
    ,
    input logic debug_en,
    input logic debug_step
`endif
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   sb;
    logic [3:0]        outst;
    logic [PERF_W-1:0] cnt;
    logic              hold;
    logic              raw_a;
    logic              raw_b;
    logic              waw;
    logic              struct_haz;
    logic              id_stall;
    logic              mem_wait;
    logic              done_ok;

`ifdef DEBUG_STEP_EN
    logic debug_step_prev;
    always_ff @(posedge clk)
        debug_step_prev <= !rst ? 1'b0 : debug_step;
    // A rising edge of debug_step lets exactly one cycle through.
    assign hold = debug_en & ~(debug_step & ~debug_step_prev);
`else
    assign hold = 1'b0;
`endif

    function automatic logic raw(input logic used, input logic [REG_AW-1:0] a);
        return used && a != '0 &&
               ((hz.wb_wen_exe && hz.is_load_exe && hz.regw_addr_exe == a) || sb[a]);
    endfunction

    function automatic logic [2:0] fwd_sel(input logic used, input logic [REG_AW-1:0] a);
        return (!used || a == '0) ? 3'd0 :
               (hz.wb_wen_exe && !hz.is_load_exe && hz.regw_addr_exe == a) ? 3'd1 :
               (hz.wb_wen_mem && hz.is_load_mem && hz.regw_addr_mem == a) ? 3'd3 :
               (hz.wb_wen_mem && !hz.is_load_mem && hz.regw_addr_mem == a) ? 3'd2 :
               (hz.wb_wen_wb && hz.regw_addr_wb == a) ? 3'd4 : 3'd0;
    endfunction

    assign raw_a      = raw(hz.rs_used, hz.addr_rs);
    assign raw_b      = raw(hz.rt_used, hz.addr_rt);
    assign waw        = hz.id_wen && hz.id_regw_addr != '0 && sb[hz.id_regw_addr];
    assign struct_haz = hz.id_long_op && outst == 4'(LONG_DEPTH);
    assign id_stall   = hz.id_valid && (raw_a || raw_b || waw || struct_haz);
    assign mem_wait   = hz.mem_req && !hz.mem_ready;
    assign done_ok    = hz.long_done && outst != '0;

    assign hz.fwd_a      = rst ? fwd_sel(hz.rs_used, hz.addr_rs) : 3'd0;
    assign hz.fwd_b      = rst ? fwd_sel(hz.rt_used, hz.addr_rt) : 3'd0;
    assign hz.long_issue = rst && hz.id_valid && hz.id_long_op && !id_stall && !mem_wait &&
                           !hz.exc_mem && !hold;
    assign hz.stall_cnt  = cnt;

    always_comb begin
        hz.if_en   = 1'b1;
        hz.id_en   = 1'b1;
        hz.exe_en  = 1'b1;
        hz.mem_en  = 1'b1;
        hz.wb_en   = 1'b1;
        hz.if_rst  = 1'b0;
        hz.id_rst  = 1'b0;
        hz.exe_rst = 1'b0;
        hz.mem_rst = 1'b0;
        hz.wb_rst  = 1'b0;
        if (!rst) begin
            hz.if_rst  = 1'b1;
            hz.id_rst  = 1'b1;
            hz.exe_rst = 1'b1;
            hz.mem_rst = 1'b1;
            hz.wb_rst  = 1'b1;
        end else if (hold) begin
            hz.if_en  = 1'b0;
            hz.id_en  = 1'b0;
            hz.exe_en = 1'b0;
            hz.mem_en = 1'b0;
            hz.wb_en  = 1'b0;
        end else if (mem_wait) begin
            hz.if_en  = 1'b0;
            hz.id_en  = 1'b0;
            hz.exe_en = 1'b0;
            hz.mem_en = 1'b0;
            hz.wb_rst = 1'b1;
        end else if (hz.exc_mem) begin
            hz.id_rst  = 1'b1;
            hz.exe_rst = 1'b1;
            hz.mem_rst = 1'b1;
        end else if (id_stall) begin
            hz.if_en   = 1'b0;
            hz.id_en   = 1'b0;
            hz.exe_rst = 1'b1;
        end else if (hz.branch_taken) begin
            hz.id_rst = 1'b1;
        end
    end

    // Clear before set so a same-cycle issue to the retiring address keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb    <= '0;
            outst <= '0;
            cnt   <= '0;
        end else begin
            if (done_ok)
                sb[hz.long_addr] <= 1'b0;
            if (hz.long_issue && hz.id_regw_addr != '0)
                sb[hz.id_regw_addr] <= 1'b1;
            outst <= outst + 4'(hz.long_issue) - 4'(done_ok);
            if ((mem_wait || id_stall) && !hold && cnt != '1)
                cnt <= cnt + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl hazards, forwarding, stage control and stall counting.
module tb_pipe_hazard_ctrl;
    localparam logic [9:0] NORM  = 10'b10_10_10_10_10;
    localparam logic [9:0] ARST  = 10'b11_11_11_11_11;
    localparam logic [9:0] STALL = 10'b00_00_11_10_10;
    localparam logic [9:0] MEMW  = 10'b00_00_00_00_11;
    localparam logic [9:0] EXC   = 10'b10_11_11_11_10;
    localparam logic [9:0] BRN   = 10'b10_11_10_10_10;

    logic clk = 1'b0;
    logic rst;
    logic [9:0] ctl;
    int vecs = 0;
    int miss = 0;

    pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(4)) hz ();
    pipe_hazard_ctrl #(.REG_AW(5), .LONG_DEPTH(2), .PERF_W(4)) dut (.clk(clk), .rst(rst), .hz(hz));

    always #5 clk = ~clk;
    assign ctl = {hz.if_en, hz.if_rst, hz.id_en, hz.id_rst, hz.exe_en, hz.exe_rst,
                  hz.mem_en, hz.mem_rst, hz.wb_en, hz.wb_rst};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.id_valid = 0; hz.rs_used = 0; hz.rt_used = 0; hz.addr_rs = 0; hz.addr_rt = 0;
        hz.id_wen = 0; hz.id_regw_addr = 0; hz.id_long_op = 0;
        hz.wb_wen_exe = 0; hz.is_load_exe = 0; hz.regw_addr_exe = 0;
        hz.wb_wen_mem = 0; hz.is_load_mem = 0; hz.regw_addr_mem = 0;
        hz.wb_wen_wb = 0; hz.regw_addr_wb = 0; hz.mem_req = 0; hz.mem_ready = 0;
        hz.long_done = 0; hz.long_addr = 0; hz.branch_taken = 0; hz.exc_mem = 0;
    endtask

    task automatic long_op(input logic [4:0] dst);
        idle();
        hz.id_valid = 1; hz.id_long_op = 1; hz.id_wen = 1; hz.id_regw_addr = dst;
    endtask

    initial begin
        rst = 0;
        idle();
        hz.id_valid = 1; hz.id_long_op = 1; hz.branch_taken = 1; hz.mem_req = 1;
        hz.rs_used = 1; hz.addr_rs = 4; hz.wb_wen_exe = 1; hz.regw_addr_exe = 4;
        #1;
        chk("rst_ctl", 32'(ctl), 32'(ARST));
        chk("rst_issue", 32'(hz.long_issue), 0);
        chk("rst_fwd", 32'(hz.fwd_a), 0);
        tick(); tick();
        chk("rst_cnt", 32'(hz.stall_cnt), 0);
        rst = 1; idle(); #1;
        chk("idle_ctl", 32'(ctl), 32'(NORM));
        // lw $1 in EXE, add $2,$1,$3 in ID
        hz.wb_wen_exe = 1; hz.is_load_exe = 1; hz.regw_addr_exe = 1;
        hz.id_valid = 1; hz.rs_used = 1; hz.addr_rs = 1; hz.rt_used = 1; hz.addr_rt = 3;
        hz.id_wen = 1; hz.id_regw_addr = 2; #1;
        chk("lu_stall", 32'(ctl), 32'(STALL));
        chk("lu_fwd0", 32'(hz.fwd_a), 0);
        tick();
        hz.wb_wen_exe = 0; hz.is_load_exe = 0; hz.regw_addr_exe = 0;
        hz.wb_wen_mem = 1; hz.is_load_mem = 1; hz.regw_addr_mem = 1; #1;
        chk("lu_go", 32'(ctl), 32'(NORM));
        chk("lu_fwd_a", 32'(hz.fwd_a), 3);
        chk("lu_fwd_b", 32'(hz.fwd_b), 0);
        chk("lu_cnt", 32'(hz.stall_cnt), 1);
        // forwarding priority
        idle();
        hz.wb_wen_exe = 1; hz.regw_addr_exe = 4; hz.wb_wen_mem = 1; hz.regw_addr_mem = 4;
        hz.wb_wen_wb = 1; hz.regw_addr_wb = 4; hz.rs_used = 1; hz.addr_rs = 4;
        hz.rt_used = 1; hz.addr_rt = 4; #1;
        chk("fwd_exe_a", 32'(hz.fwd_a), 1);
        chk("fwd_exe_b", 32'(hz.fwd_b), 1);
        hz.regw_addr_exe = 9; #1;
        chk("fwd_mem_alu", 32'(hz.fwd_a), 2);
        hz.is_load_mem = 1; #1;
        chk("fwd_mem_din", 32'(hz.fwd_a), 3);
        hz.wb_wen_mem = 0; #1;
        chk("fwd_wb", 32'(hz.fwd_a), 4);
        hz.rs_used = 0; #1;
        chk("fwd_unused", 32'(hz.fwd_a), 0);
        chk("fwd_wb_b", 32'(hz.fwd_b), 4);
        hz.regw_addr_wb = 0; hz.addr_rt = 0; #1;
        chk("fwd_r0", 32'(hz.fwd_b), 0);
        // div $5 then dependent add $6,$5,$0
        long_op(5); #1;
        chk("div_issue", 32'(hz.long_issue), 1);
        chk("div_ctl", 32'(ctl), 32'(NORM));
        tick();
        idle(); hz.id_valid = 1; hz.rs_used = 1; hz.addr_rs = 5; hz.id_wen = 1; hz.id_regw_addr = 6; #1;
        chk("sb_stall", 32'(ctl), 32'(STALL));
        chk("sb_noissue", 32'(hz.long_issue), 0);
        tick();
        chk("sb_cnt", 32'(hz.stall_cnt), 2);
        hz.long_done = 1; hz.long_addr = 5; #1;
        chk("sb_done_stall", 32'(ctl), 32'(STALL));
        tick();
        hz.long_done = 0; #1;
        chk("sb_clear", 32'(ctl), 32'(NORM));
        chk("sb_cnt2", 32'(hz.stall_cnt), 3);
        tick();
        // structural limit at two in flight
        long_op(8); #1;
        chk("st_i1", 32'(hz.long_issue), 1);
        tick();
        long_op(9); #1;
        chk("st_i2", 32'(hz.long_issue), 1);
        tick();
        long_op(10); #1;
        chk("st_i3", 32'(hz.long_issue), 0);
        chk("st_ctl", 32'(ctl), 32'(STALL));
        tick();
        hz.long_done = 1; hz.long_addr = 8; #1;
        chk("st_done_stall", 32'(ctl), 32'(STALL));
        tick();
        hz.long_addr = 9; #1;
        chk("st_i3_go", 32'(hz.long_issue), 1);
        tick();
        long_op(11); #1;
        chk("st_i4", 32'(hz.long_issue), 1);
        tick();
        long_op(12); #1;
        chk("st_i5", 32'(hz.long_issue), 0);
        chk("st_cnt", 32'(hz.stall_cnt), 5);
        // memory wait over a pending branch
        idle(); hz.mem_req = 1; hz.branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_ctl", 32'(ctl), 32'(MEMW));
            tick();
        end
        hz.mem_ready = 1; #1;
        chk("mw_branch", 32'(ctl), 32'(BRN));
        chk("mw_cnt", 32'(hz.stall_cnt), 8);
        tick();
        // exception while ID waits on the scoreboard
        idle(); hz.id_valid = 1; hz.rs_used = 1; hz.addr_rs = 10; #1;
        chk("ex_pre", 32'(ctl), 32'(STALL));
        hz.exc_mem = 1; #1;
        chk("ex_ctl", 32'(ctl), 32'(EXC));
        tick();
        hz.exc_mem = 0; #1;
        chk("ex_sb_kept", 32'(ctl), 32'(STALL));
        tick();
        chk("ex_cnt", 32'(hz.stall_cnt), 10);
        // reset with sb[7] pending and one op in flight
        idle(); hz.long_done = 1; hz.long_addr = 10; tick();
        hz.long_addr = 11; tick();
        long_op(7); #1;
        chk("r_issue7", 32'(hz.long_issue), 1);
        tick();
        idle(); hz.id_valid = 1; hz.rs_used = 1; hz.addr_rs = 7; #1;
        chk("r_pre", 32'(ctl), 32'(STALL));
        rst = 0; #1;
        chk("r_ctl", 32'(ctl), 32'(ARST));
        tick();
        chk("r_cnt", 32'(hz.stall_cnt), 0);
        rst = 1; #1;
        chk("r_sb_gone", 32'(ctl), 32'(NORM));
        idle(); hz.long_done = 1; hz.long_addr = 7; tick();
        long_op(13); #1;
        chk("r_i1", 32'(hz.long_issue), 1);
        tick();
        long_op(14); #1;
        chk("r_i2", 32'(hz.long_issue), 1);
        tick();
        long_op(15); #1;
        chk("r_no_underflow", 32'(hz.long_issue), 0);
        // saturation of the 4-bit counter
        repeat (14) tick();
        chk("sat_14", 32'(hz.stall_cnt), 14);
        repeat (3) tick();
        chk("sat_15", 32'(hz.stall_cnt), 15);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
